// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: qualifies the raw PLL lock indication against DCO drift,
// rides through short lock dropouts and flags acquisition timeouts as a fault.
module pll_lock_supervisor #(
    parameter int unsigned LOCK_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES = 64,
    parameter int unsigned ACQ_TIMEOUT = 65536,
    parameter logic [31:0] DRIFT_TOL   = 32'h0010_0000
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        lock_in,
    input  logic [31:0] dco_word,
    input  logic        clear_fault,
    output logic        pll_locked,
    output logic        lock_lost_pulse,
    output logic        fault,
    output logic [2:0]  state,
    output logic [15:0] loss_count,
    output logic [31:0] dco_hold
);

    // state    | meaning
    // DISABLED | supervisor off, waiting for enable
    // ACQUIRE  | waiting for raw lock_in
    // QUALIFY  | counting consecutive lock cycles within drift of ref_word
    // LOCKED   | qualified lock, DCO tracked against dco_hold
    // HOLDOVER | lock disturbed, grace period before declaring loss
    // FAULT    | acquisition timed out, waiting for clear_fault
    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_ACQUIRE  = 3'd1,
        ST_QUALIFY  = 3'd2,
        ST_LOCKED   = 3'd3,
        ST_HOLDOVER = 3'd4,
        ST_FAULT    = 3'd5
    } state_e;

    localparam logic [31:0] QUAL_LAST = 32'(LOCK_CYCLES - 1);
    localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] ACQ_LAST  = 32'(ACQ_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] acq_q, acq_d;
    logic [31:0] qual_q, qual_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] ref_q, ref_d;
    logic [31:0] dco_hold_q, dco_hold_d;
    logic [15:0] loss_q, loss_d;
    logic        pulse_q, pulse_d;

    logic        ref_ok;
    logic        hold_ok;
    logic        timeout;
    logic [31:0] acq_inc;

    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    always_comb begin
        ref_ok  = lock_in && (abs_diff(dco_word, ref_q) <= DRIFT_TOL);
        hold_ok = lock_in && (abs_diff(dco_word, dco_hold_q) <= DRIFT_TOL);
        timeout = (acq_q == ACQ_LAST);
        acq_inc = (acq_q == 32'hFFFF_FFFF) ? acq_q : acq_q + 32'd1;
    end

    always_comb begin
        state_d    = state_q;
        acq_d      = acq_q;
        qual_d     = qual_q;
        hold_d     = hold_q;
        ref_d      = ref_q;
        dco_hold_d = dco_hold_q;
        loss_d     = loss_q;
        pulse_d    = 1'b0;

        if (!enable) begin
            state_d = ST_DISABLED;
            acq_d   = '0;
            qual_d  = '0;
            hold_d  = '0;
        end else begin
            unique case (state_q)
                ST_DISABLED: begin
                    state_d = ST_ACQUIRE;
                    acq_d   = '0;
                end
                ST_ACQUIRE: begin
                    acq_d = acq_inc;
                    if (timeout) begin
                        state_d = ST_FAULT;
                    end else if (lock_in) begin
                        state_d = ST_QUALIFY;
                        qual_d  = '0;
                        ref_d   = dco_word;
                    end
                end
                ST_QUALIFY: begin
                    acq_d = acq_inc;
                    // timeout wins even when this cycle would complete qualification
                    if (timeout) begin
                        state_d = ST_FAULT;
                    end else if (ref_ok) begin
                        if (qual_q == QUAL_LAST) begin
                            state_d    = ST_LOCKED;
                            dco_hold_d = dco_word;
                        end else begin
                            qual_d = qual_q + 32'd1;
                        end
                    end else begin
                        state_d = ST_ACQUIRE;
                    end
                end
                ST_LOCKED: begin
                    if (!hold_ok) begin
                        state_d = ST_HOLDOVER;
                        hold_d  = '0;
                    end
                end
                ST_HOLDOVER: begin
                    if (hold_ok) begin
                        state_d = ST_LOCKED;
                    end else if (hold_q == HOLD_LAST) begin
                        state_d = ST_ACQUIRE;
                        acq_d   = '0;
                        pulse_d = 1'b1;
                        if (loss_q != 16'hFFFF) begin
                            loss_d = loss_q + 16'd1;
                        end
                    end else begin
                        hold_d = hold_q + 32'd1;
                    end
                end
                ST_FAULT: begin
                    if (clear_fault) begin
                        state_d = ST_ACQUIRE;
                        acq_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_DISABLED;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_DISABLED;
            acq_q      <= '0;
            qual_q     <= '0;
            hold_q     <= '0;
            ref_q      <= '0;
            dco_hold_q <= '0;
            loss_q     <= '0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acq_q      <= acq_d;
            qual_q     <= qual_d;
            hold_q     <= hold_d;
            ref_q      <= ref_d;
            dco_hold_q <= dco_hold_d;
            loss_q     <= loss_d;
            pulse_q    <= pulse_d;
        end
    end

    assign state           = state_q;
    assign pll_locked      = (state_q == ST_LOCKED) || (state_q == ST_HOLDOVER);
    assign fault           = (state_q == ST_FAULT);
    assign lock_lost_pulse = pulse_q;
    assign loss_count      = loss_q;
    assign dco_hold        = dco_hold_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor with small timing parameters
// (LOCK_CYCLES=8, HOLD_CYCLES=4, ACQ_TIMEOUT=32, DRIFT_TOL=16).
module tb_pll_lock_supervisor;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        lock_in;
    logic [31:0] dco_word;
    logic        clear_fault;
    logic        pll_locked;
    logic        lock_lost_pulse;
    logic        fault;
    logic [2:0]  state;
    logic [15:0] loss_count;
    logic [31:0] dco_hold;

    typedef struct packed {
        logic [2:0] st;
        logic       pulse;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    pll_lock_supervisor #(
        .LOCK_CYCLES(8),
        .HOLD_CYCLES(4),
        .ACQ_TIMEOUT(32),
        .DRIFT_TOL(32'd16)
    ) dut (
        .sys_clk        (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .lock_in        (lock_in),
        .dco_word       (dco_word),
        .clear_fault    (clear_fault),
        .pll_locked     (pll_locked),
        .lock_lost_pulse(lock_lost_pulse),
        .fault          (fault),
        .state          (state),
        .loss_count     (loss_count),
        .dco_hold       (dco_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, state=%0d", state);
        $fatal(1);
    end

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; lock_in = 1'b0; dco_word = '0; clear_fault = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n_cmp++;
        if (state !== 3'd0 || pll_locked !== 1'b0 || fault !== 1'b0 || lock_lost_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: state=%0d locked=%b fault=%b pulse=%b, expected 0/0/0/0",
                     state, pll_locked, fault, lock_lost_pulse);
        end
        n_cmp++;
        if (loss_count !== 16'd0 || dco_hold !== 32'd0) begin
            n_err++;
            $display("FAIL reset_regs: loss_count=%0d dco_hold=%0d, expected 0/0", loss_count, dco_hold);
        end
    endtask

    task automatic test_lock_acquire();
        exp_t e;
        enable = 1'b1; lock_in = 1'b1; dco_word = 32'd1000;
        for (int k = 0; k <= 10; k++) begin
            sbq.push_back('{st: (k == 0) ? 3'd1 : (k <= 8) ? 3'd2 : 3'd3, pulse: 1'b0});
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_cmp++;
            if (state !== e.st || lock_lost_pulse !== e.pulse ||
                pll_locked !== (e.st inside {3'd3, 3'd4}) || fault !== (e.st == 3'd5)) begin
                n_err++;
                $display("FAIL lock_acquire k=%0d: state=%0d pulse=%b locked=%b fault=%b, expected state=%0d pulse=%b",
                         k, state, lock_lost_pulse, pll_locked, fault, e.st, e.pulse);
            end
        end
        n_cmp++;
        if (dco_hold !== 32'd1000) begin
            n_err++;
            $display("FAIL lock_dco_hold: dco_hold=%0d, expected 1000", dco_hold);
        end
    endtask

    task automatic test_holdover_recover();
        exp_t e;
        for (int k = 0; k <= 3; k++) begin
            lock_in  = (k >= 2);
            dco_word = (k >= 2) ? 32'd1010 : 32'd1000;
            sbq.push_back('{st: (k < 2) ? 3'd4 : 3'd3, pulse: 1'b0});
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_cmp++;
            if (state !== e.st || lock_lost_pulse !== e.pulse ||
                pll_locked !== (e.st inside {3'd3, 3'd4}) || fault !== (e.st == 3'd5)) begin
                n_err++;
                $display("FAIL holdover_recover k=%0d: state=%0d pulse=%b locked=%b fault=%b, expected state=%0d pulse=%b",
                         k, state, lock_lost_pulse, pll_locked, fault, e.st, e.pulse);
            end
        end
        n_cmp++;
        if (loss_count !== 16'd0 || dco_hold !== 32'd1000) begin
            n_err++;
            $display("FAIL recover_regs: loss_count=%0d dco_hold=%0d, expected 0/1000", loss_count, dco_hold);
        end
    endtask

    task automatic test_drift_loss();
        exp_t e;
        logic [2:0] st;
        lock_in = 1'b1; dco_word = 32'd1017;
        for (int k = 0; k <= 14; k++) begin
            if (k <= 3)       st = 3'd4;
            else if (k == 4)  st = 3'd1;
            else if (k <= 12) st = 3'd2;
            else              st = 3'd3;
            sbq.push_back('{st: st, pulse: (k == 4)});
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_cmp++;
            if (state !== e.st || lock_lost_pulse !== e.pulse ||
                pll_locked !== (e.st inside {3'd3, 3'd4}) || fault !== (e.st == 3'd5)) begin
                n_err++;
                $display("FAIL drift_loss k=%0d: state=%0d pulse=%b locked=%b fault=%b, expected state=%0d pulse=%b",
                         k, state, lock_lost_pulse, pll_locked, fault, e.st, e.pulse);
            end
            if (k == 4) begin
                n_cmp++;
                if (loss_count !== 16'd1) begin
                    n_err++;
                    $display("FAIL drift_loss_count: loss_count=%0d, expected 1", loss_count);
                end
            end
        end
        n_cmp++;
        if (dco_hold !== 32'd1017 || loss_count !== 16'd1) begin
            n_err++;
            $display("FAIL relock_regs: dco_hold=%0d loss_count=%0d, expected 1017/1", dco_hold, loss_count);
        end
    endtask

    task automatic test_reset_in_holdover();
        exp_t e;
        lock_in = 1'b0;
        for (int k = 0; k <= 1; k++) begin
            sbq.push_back('{st: 3'd4, pulse: 1'b0});
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_cmp++;
            if (state !== e.st || lock_lost_pulse !== e.pulse) begin
                n_err++;
                $display("FAIL pre_reset_holdover k=%0d: state=%0d pulse=%b, expected state=%0d pulse=%b",
                         k, state, lock_lost_pulse, e.st, e.pulse);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (state !== 3'd0 || pll_locked !== 1'b0 || fault !== 1'b0 || lock_lost_pulse !== 1'b0 ||
            loss_count !== 16'd0 || dco_hold !== 32'd0) begin
            n_err++;
            $display("FAIL async_reset: state=%0d locked=%b fault=%b pulse=%b loss=%0d hold=%0d, expected all 0",
                     state, pll_locked, fault, lock_lost_pulse, loss_count, dco_hold);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (state !== 3'd0 || lock_lost_pulse !== 1'b0 || loss_count !== 16'd0) begin
                n_err++;
                $display("FAIL reset_held k=%0d: state=%0d pulse=%b loss=%0d, expected 0/0/0",
                         k, state, lock_lost_pulse, loss_count);
            end
        end
        enable = 1'b0;
        rst_n  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sbq.push_back('{st: 3'd0, pulse: 1'b0});
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_cmp++;
            if (state !== e.st || lock_lost_pulse !== e.pulse || loss_count !== 16'd0) begin
                n_err++;
                $display("FAIL post_reset k=%0d: state=%0d pulse=%b loss=%0d, expected state=%0d pulse=%b loss=0",
                         k, state, lock_lost_pulse, loss_count, e.st, e.pulse);
            end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        enable = 1'b1; lock_in = 1'b0; dco_word = 32'd500; clear_fault = 1'b0;
        for (int k = 0; k <= 38; k++) begin
            logic [2:0] st;
            if (k < 32)       st = 3'd1;
            else if (k < 36)  st = 3'd5;
            else if (k < 38)  st = 3'd1;
            else              st = 3'd0;
            clear_fault = (k == 36);
            enable      = (k != 38);
            sbq.push_back('{st: st, pulse: 1'b0});
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_cmp++;
            if (state !== e.st || lock_lost_pulse !== e.pulse ||
                pll_locked !== (e.st inside {3'd3, 3'd4}) || fault !== (e.st == 3'd5)) begin
                n_err++;
                $display("FAIL timeout k=%0d: state=%0d pulse=%b locked=%b fault=%b, expected state=%0d pulse=%b",
                         k, state, lock_lost_pulse, pll_locked, fault, e.st, e.pulse);
            end
        end
        clear_fault = 1'b0;
    endtask

    task automatic test_timeout_priority();
        exp_t e;
        enable = 1'b1; dco_word = 32'd2000;
        for (int k = 0; k <= 33; k++) begin
            logic [2:0] st;
            lock_in = (k >= 24);
            if (k < 24)       st = 3'd1;
            else if (k < 32)  st = 3'd2;
            else              st = 3'd5;
            sbq.push_back('{st: st, pulse: 1'b0});
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_cmp++;
            if (state !== e.st || lock_lost_pulse !== e.pulse ||
                pll_locked !== (e.st inside {3'd3, 3'd4}) || fault !== (e.st == 3'd5)) begin
                n_err++;
                $display("FAIL timeout_priority k=%0d: state=%0d pulse=%b locked=%b fault=%b, expected state=%0d pulse=%b",
                         k, state, lock_lost_pulse, pll_locked, fault, e.st, e.pulse);
            end
        end
        enable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_toggle();
        exp_t       e;
        logic [2:0] m_st;
        int         m_acq;
        int         saw_qual;
        enable = 1'b1; dco_word = 32'd3000; lock_in = 1'b0;
        m_st = 3'd1; m_acq = 0; saw_qual = 0;
        for (int k = 0; k <= 40; k++) begin
            lock_in = ((k / 5) % 2 == 1);
            if (k > 0) begin
                if (m_st != 3'd5) begin
                    if (m_acq == 31)                   m_st = 3'd5;
                    else if (m_st == 3'd1 && lock_in)  m_st = 3'd2;
                    else if (m_st == 3'd2 && !lock_in) m_st = 3'd1;
                    m_acq++;
                end
            end
            sbq.push_back('{st: m_st, pulse: 1'b0});
            @(posedge clk); #1;
            e = sbq.pop_front();
            if (state == 3'd2) saw_qual++;
            n_cmp++;
            if (state !== e.st || lock_lost_pulse !== e.pulse ||
                pll_locked !== (e.st inside {3'd3, 3'd4}) || fault !== (e.st == 3'd5)) begin
                n_err++;
                $display("FAIL toggle k=%0d: state=%0d pulse=%b locked=%b fault=%b, expected state=%0d pulse=%b",
                         k, state, lock_lost_pulse, pll_locked, fault, e.st, e.pulse);
            end
        end
        n_cmp++;
        if (saw_qual == 0 || fault !== 1'b1) begin
            n_err++;
            $display("FAIL toggle_end: qualify_cycles=%0d fault=%b, expected >0 and 1", saw_qual, fault);
        end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_holdover_recover();
        test_drift_loss();
        test_reset_in_holdover();
        test_timeout();
        test_timeout_priority();
        test_toggle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
